// File: rtl/dec_ascii_streamer_pkg.sv
// Shared definitions for the decimal ASCII streamer.
// Holds the controller state encoding, the ASCII constants, and the digit-count helper.
// The digit-count helper sizes the BCD register so that any WIDTH-bit magnitude fits.
package dec_ascii_streamer_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CONVERT   = 2'd1,
        S_EMIT_SIGN = 2'd2,
        S_EMIT_DIG  = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;

    // floor(WIDTH*log10(2))+1, with 1233/4096 approximating log10(2).
    // The result is 5 for WIDTH 16 and 10 for WIDTH 32.
    function automatic int dec_digits(input int width);
        return ((width * 1233) >> 12) + 1;
    endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// Performs one double-dabble step: each nibble >= 5 gets +3, then {bcd, shift_in} shifts left by one bit.
// Latency: combinational. Backpressure: none (pure function).
// Ports: bcd_i current BCD digits, shift_in_i next binary bit (MSB first), bcd_o updated BCD digits.
module bcd_dd_step #(
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic                shift_in_i,
    output logic [4*DIGITS-1:0] bcd_o
);

    logic [3:0] nib;
    logic [3:0] adj;
    logic       carry;

    // The shift is folded into the per-nibble loop.
    // Each nibble takes the top bit of the adjusted nibble below it.
    // The top nibble never carries out, because DIGITS is sized for the full WIDTH range.
    always_comb begin
        bcd_o = '0;
        nib   = '0;
        adj   = '0;
        carry = shift_in_i;
        for (int i = 0; i < DIGITS; i++) begin
            nib = bcd_i[4*i +: 4];
            adj = (nib >= 4'd5) ? (nib + 4'd3) : nib;
            bcd_o[4*i +: 4] = {adj[2:0], carry};
            carry = adj[3];
        end
    end

endmodule

// File: rtl/dec_ascii_streamer.sv
// Formats a WIDTH-bit signed or unsigned integer as decimal ASCII, emitting one character per handshake.
// Latency: the first character is valid WIDTH+1 cycles after acceptance (one conversion bit per clock).
// Backpressure: characters hold stable until out_ready_i; no new value is accepted until the last character handshakes.
// Ports: in_* value handshake (in_ready_o high only when idle); out_* character stream, with out_last_o on the final digit.
module dec_ascii_streamer
    import dec_ascii_streamer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_value_i,
    input  logic             in_signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_char_o,
    output logic             out_last_o
);

    localparam int DIGITS = dec_digits(WIDTH);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W  = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_char_q, out_char_d;
    logic               out_last_q, out_last_d;

    logic [BCD_W-1:0]   step_bcd;
    logic [IDX_W-1:0]   msnz;
    logic [3:0]         sel_nib;

    bcd_dd_step #(.DIGITS(DIGITS)) u_step (
        .bcd_i      (bcd_q),
        .shift_in_i (mag_q[WIDTH-1]),
        .bcd_o      (step_bcd)
    );

    // Find the most-significant nonzero digit of the final BCD value.
    // This suppresses leading zeros; an all-zero value selects digit 0.
    always_comb begin
        msnz = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (step_bcd[4*i +: 4] != 4'd0) begin
                msnz = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        neg_d   = neg_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    neg_d   = in_signed_i & in_value_i[WIDTH-1];
                    // For the most negative value, the WIDTH-bit negation yields the correct unsigned magnitude.
                    mag_d   = neg_d ? (~in_value_i + {{(WIDTH-1){1'b0}}, 1'b1}) : in_value_i;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CONVERT;
                end
            end
            S_CONVERT: begin
                bcd_d = step_bcd;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    idx_d   = msnz;
                    state_d = neg_q ? S_EMIT_SIGN : S_EMIT_DIG;
                end
            end
            S_EMIT_SIGN: begin
                if (out_ready_i) begin
                    state_d = S_EMIT_DIG;
                end
            end
            S_EMIT_DIG: begin
                if (out_ready_i) begin
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so that the registered values line up with the state register.
    always_comb begin
        sel_nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == idx_d) begin
                sel_nib = bcd_d[4*i +: 4];
            end
        end
    end

    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_EMIT_SIGN) || (state_d == S_EMIT_DIG);
        out_char_d  = 8'h00;
        out_last_d  = 1'b0;
        if (state_d == S_EMIT_SIGN) begin
            out_char_d = ASCII_MINUS;
        end else if (state_d == S_EMIT_DIG) begin
            out_char_d = ASCII_ZERO + {4'h0, sel_nib};
            out_last_d = (idx_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_char_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            out_last_q  <= out_last_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_char_o  = out_char_q;
    assign out_last_o  = out_last_q;

endmodule
